// File: rtl/cpu_sequencer.sv
// Eight-phase control sequencer for the lab CPU: one instruction per 8 clocks, sticky halt.
// Optional single-step gating at INST_ADDR is enabled by defining CPU_SEQ_STEP_EN.
module cpu_sequencer #(
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
`ifdef CPU_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               load_ir,
  output logic               load_ac,
  output logic               inc_pc,
  output logic               load_pc,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t state;
  logic   halted;
  logic   start_ok;
  logic   alu_op;

`ifdef CPU_SEQ_STEP_EN
  assign start_ok = step;
`else
  assign start_ok = 1'b1;
`endif

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase  = state;

  // HLT freezes the phase at OP_ADDR; only reset releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else if (!halted) begin
      if (state == OP_ADDR && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else if (state != INST_ADDR || start_ok) begin
        state <= phase_t'(state + PHASE_W'(1));
      end
    end
  end

  // Opcode is only consulted from OP_ADDR on, so an unknown opcode early in the fetch is harmless.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    halt    = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR: ;
        INST_FETCH: mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: mem_rd = alu_op;
        ALU_OP: begin
          mem_rd  = alu_op;
          load_ac = alu_op;
          inc_pc  = (opcode == OP_SKZ) && zero;
          load_pc = (opcode == OP_JMP);
        end
        STORE: begin
          mem_rd  = alu_op;
          load_ac = alu_op;
          mem_wr  = (opcode == OP_STO);
          inc_pc  = (opcode == OP_JMP);
          load_pc = (opcode == OP_JMP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed then random instructions against a phase-table model,
// plus an external PC counter whose value is compared with per-instruction PC arithmetic.
module tb_cpu_sequencer;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
  logic [2:0] phase;
`ifdef CPU_SEQ_STEP_EN
  logic       step;
`endif

  int         checks = 0;
  int         failures = 0;
  int         m_phase;
  bit         m_halted;
  logic [2:0] cur_op;
  logic       cur_zero;
  logic [4:0] target, pc_cnt, pc_exp;
  logic [2:0] forced_ops[$];
  logic       forced_zero[$];
  logic [4:0] forced_tgt[$];

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef CPU_SEQ_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .zero(zero), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .load_ir(load_ir), .load_ac(load_ac), .inc_pc(inc_pc), .load_pc(load_pc),
    .halt(halt), .phase(phase)
  );

  // External program counter: load wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_cnt <= 5'd0;
    else if (load_pc) pc_cnt <= target;
    else if (inc_pc) pc_cnt <= pc_cnt + 5'd1;
  end

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {halt, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc} from the phase table
  function automatic logic [7:0] expStrobes();
    bit alu;
    logic [7:0] s;
    alu = (cur_op == ADD) || (cur_op == AND_) || (cur_op == XOR_) || (cur_op == LDA);
    if (m_halted) return 8'b0100_0000;
    s = 8'd0;
    s[6] = (m_phase == 4) && (cur_op == HLT);
    s[5] = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu);
    s[4] = (m_phase == 7) && (cur_op == STO);
    s[3] = (m_phase == 2) || (m_phase == 3);
    s[2] = (m_phase >= 6) && alu;
    s[1] = (m_phase == 4) || (m_phase == 6 && cur_op == SKZ && cur_zero) ||
           (m_phase == 7 && cur_op == JMP);
    s[0] = (m_phase >= 6) && (cur_op == JMP);
    return s;
  endfunction

  task automatic checkOutput();
    checkVal("phase", 8'(phase), 8'(m_phase));
    checkVal("strobes", {1'b0, halt, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc},
             expStrobes());
    checkVal("rd_wr_excl", 8'(mem_rd & mem_wr), 8'd0);
    if (m_phase == 0 && !m_halted) checkVal("pc", 8'(pc_cnt), 8'(pc_exp));
  endtask

  task automatic applyStimulus();
    if (m_phase == 0 && !m_halted) begin
      if (forced_ops.size() > 0) begin
        cur_op   = forced_ops.pop_front();
        cur_zero = forced_zero.pop_front();
        target   = forced_tgt.pop_front();
      end else begin
        cur_op   = 3'($urandom_range(7, 1));
        cur_zero = 1'($urandom_range(1, 0));
        target   = 5'($urandom);
      end
    end
    opcode = (m_phase < 3 && !m_halted) ? 3'bxxx : cur_op;
    zero   = cur_zero;
`ifdef CPU_SEQ_STEP_EN
    step   = ($urandom_range(3, 0) != 0);
`endif
  endtask

  task automatic runCycle();
    bit adv;
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
`ifdef CPU_SEQ_STEP_EN
    adv = step;
`else
    adv = 1'b1;
`endif
    if (!m_halted) begin
      if (m_phase == 4 && cur_op == HLT) m_halted = 1'b1;
      else if (m_phase != 0 || adv) begin
        if (m_phase == 7) begin
          if (cur_op == JMP) pc_exp = target;
          else if (cur_op == SKZ && cur_zero) pc_exp = pc_exp + 5'd2;
          else pc_exp = pc_exp + 5'd1;
        end
        m_phase = (m_phase + 1) % 8;
      end
    end
    @(negedge clk);
  endtask

  task automatic pushOp(input logic [2:0] op, input logic z, input logic [4:0] t);
    forced_ops.push_back(op);
    forced_zero.push_back(z);
    forced_tgt.push_back(t);
  endtask

  initial begin
    int budget;
    rst = 1'b1; opcode = 3'bxxx; zero = 1'b0; target = 5'd0;
`ifdef CPU_SEQ_STEP_EN
    step = 1'b0;
`endif
    cur_op = ADD; cur_zero = 1'b0;
    m_phase = 0; m_halted = 1'b0; pc_exp = 5'd0;
    #2;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    pushOp(ADD, 1'b0, 5'd3);
    pushOp(SKZ, 1'b1, 5'd4);
    pushOp(SKZ, 1'b0, 5'd5);
    pushOp(JMP, 1'b0, 5'h1A);
    pushOp(STO, 1'b1, 5'd9);
    pushOp(LDA, 1'b1, 5'd2);
    budget = 0;
    while (forced_ops.size() > 0 && budget < 400) begin
      runCycle();
      budget++;
    end
    for (int i = 0; i < 400; i++) runCycle();

    // Directed halt: wait for it, then hold for 20 clocks.
    while (m_phase != 0) runCycle();
    pushOp(HLT, 1'b0, 5'd0);
    budget = 0;
    while (!m_halted && budget < 200) begin
      runCycle();
      budget++;
    end
    checkVal("halt_reached", 8'(m_halted), 8'd1);
    for (int i = 0; i < 20; i++) runCycle();

    // Reset mid-cycle acts before the next clock edge.
    #2 rst = 1'b1;
    m_phase = 0; m_halted = 1'b0; pc_exp = 5'd0;
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    pushOp(ADD, 1'b0, 5'd0);
    for (int i = 0; i < 24; i++) runCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
